// File: rtl/present_drop_scheduler.sv
// present_drop_scheduler
// Turns rope-pops-ball events into spaced present drops for the presents controller.
// A free-running 16-bit Galois LFSR gates each drop chance and picks the present type.
// Accepted chances queue in a small saturating counter. Drops are released one per
// DROP state and are separated by a cooldown that is counted in secClk pulses.
// Optional feature: define PRESENT_TYPE_BALANCE_EN so that no type repeats back-to-back.
// resetN is synchronous and active-high, despite its name.
module present_drop_scheduler #(
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int unsigned DROP_PROB    = 4,
    parameter int unsigned COOLDOWN_SEC = 3,
    parameter int unsigned MAX_PENDING  = 3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       secClk,
    input  logic       ballPop,
    input  logic       presentsVisible,
    output logic       dropPresent,
    output logic [2:0] nxt_present,
    output logic [1:0] pending
);

    // Taps for x^16 + x^14 + x^13 + x^11 in right-shifting Galois form.
    localparam logic [15:0] LfsrMask     = 16'hB400;
    // A 5-bit threshold lets DROP_PROB = 16 accept every chance.
    localparam logic [4:0]  DropThresh   = 5'(DROP_PROB);
    localparam logic [1:0]  MaxPending   = 2'(MAX_PENDING);
    localparam logic [3:0]  CooldownInit = 4'(COOLDOWN_SEC);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StDrop     = 2'd1,
        StCooldown = 2'd2
    } state_e;

    state_e      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [1:0]  pending_q;
    logic [1:0]  pending_d;
    logic [3:0]  cooldown_q;
    logic [1:0]  drop_type;
    logic        accept;
    logic        drop_dec;
    logic        start_drop;

    // Next LFSR value: shift right, fold the taps in when a one falls out.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LfsrMask;
        end
    end

    // LFSR advances every clock and never stalls.
    always_ff @(posedge clk) begin
        if (resetN) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // A chance is taken only when presents may appear and the queue has room;
    // a pop against a full queue is simply dropped.
    assign accept = ballPop && presentsVisible &&
                    ({1'b0, lfsr_q[3:0]} < DropThresh) &&
                    (pending_q < MaxPending);

    // The DROP cycle consumes one queued chance.
    assign drop_dec = (state_q == StDrop) && (pending_q != 2'd0);

    // Leave IDLE only when something is queued and presents are allowed.
    assign start_drop = (state_q == StIdle) && (pending_q != 2'd0) && presentsVisible;

`ifdef PRESENT_TYPE_BALANCE_EN
    logic [1:0] last_type_q;

    // Bump the raw type by one when it would repeat the previous drop.
    always_comb begin
        drop_type = lfsr_q[5:4];
        if (drop_type == last_type_q) begin
            drop_type = drop_type + 2'd1;
        end
    end

    // Remember the type that was actually issued in each DROP cycle.
    always_ff @(posedge clk) begin
        if (resetN) begin
            last_type_q <= 2'd0;
        end else if (state_q == StDrop) begin
            last_type_q <= nxt_present[1:0];
        end
    end
`else
    assign drop_type = lfsr_q[5:4];
`endif

    // Queue arithmetic: losing visibility flushes it; accept and drop together cancel.
    always_comb begin
        pending_d = pending_q;
        if (!presentsVisible) begin
            pending_d = 2'd0;
        end else if (accept && !drop_dec) begin
            pending_d = pending_q + 2'd1;
        end else if (!accept && drop_dec) begin
            pending_d = pending_q - 2'd1;
        end
    end

    // Drop FSM with registered queue, cooldown and present type.
    always_ff @(posedge clk) begin
        if (resetN) begin
            state_q     <= StIdle;
            pending_q   <= 2'd0;
            cooldown_q  <= 4'd0;
            nxt_present <= 3'd0;
        end else begin
            pending_q <= pending_d;
            unique case (state_q)
                StIdle: begin
                    if (start_drop) begin
                        state_q     <= StDrop;
                        // Type is captured here so it is valid during the drop pulse.
                        nxt_present <= {1'b0, drop_type};
                    end
                end
                StDrop: begin
                    // secClk in this cycle is ignored: the cooldown is (re)loaded.
                    if (CooldownInit == 4'd0 || !presentsVisible) begin
                        state_q    <= StIdle;
                        cooldown_q <= 4'd0;
                    end else begin
                        state_q    <= StCooldown;
                        cooldown_q <= CooldownInit;
                    end
                end
                StCooldown: begin
                    if (!presentsVisible || cooldown_q == 4'd0) begin
                        state_q    <= StIdle;
                        cooldown_q <= 4'd0;
                    end else if (secClk) begin
                        cooldown_q <= cooldown_q - 4'd1;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    cooldown_q <= 4'd0;
                end
            endcase
        end
    end

    // Moore outputs decoded from registers.
    assign dropPresent = (state_q == StDrop);
    assign pending     = pending_q;

endmodule

// File: tb/tb_present_drop_scheduler.sv
// Directed bench for present_drop_scheduler.
// dut: DROP_PROB=16 (every chance taken), COOLDOWN_SEC=3, MAX_PENDING=3.
// dut0: DROP_PROB=0 (no chance ever taken), sharing all inputs.
// Present types are predicted from a reference LFSR built from the polynomial.
module tb_present_drop_scheduler;

    localparam logic [15:0] Seed = 16'hACE1;

    logic       clk = 1'b0;
    logic       resetN;
    logic       secClk;
    logic       ballPop;
    logic       presentsVisible;
    logic       dropPresent;
    logic [2:0] nxt_present;
    logic [1:0] pending;
    logic       drop0;
    logic [2:0] nxt0;
    logic [1:0] pend0;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    logic [1:0]  exp_type;
`ifdef PRESENT_TYPE_BALANCE_EN
    logic [1:0]  exp_last;
    logic [1:0]  prev_type;
`endif

    present_drop_scheduler #(
        .LFSR_SEED   (Seed),
        .DROP_PROB   (16),
        .COOLDOWN_SEC(3),
        .MAX_PENDING (3)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .secClk         (secClk),
        .ballPop        (ballPop),
        .presentsVisible(presentsVisible),
        .dropPresent    (dropPresent),
        .nxt_present    (nxt_present),
        .pending        (pending)
    );

    present_drop_scheduler #(
        .LFSR_SEED   (Seed),
        .DROP_PROB   (0),
        .COOLDOWN_SEC(3),
        .MAX_PENDING (3)
    ) dut0 (
        .clk            (clk),
        .resetN         (resetN),
        .secClk         (secClk),
        .ballPop        (ballPop),
        .presentsVisible(presentsVisible),
        .dropPresent    (drop0),
        .nxt_present    (nxt0),
        .pending        (pend0)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0] == 1'b1) r = r ^ 16'hB400;
        return r;
    endfunction

    // Reference LFSR; m_prev holds the value seen by the DUT in the previous cycle.
    always @(posedge clk) begin
        m_prev <= m_lfsr;
        if (resetN) m_lfsr <= Seed;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sec_pulse();
        secClk = 1'b1;
        tick();
        secClk = 1'b0;
    endtask

    // Called in a cycle where a drop is expected; type comes from the previous-cycle LFSR.
    task automatic check_drop(input string tag);
        logic [1:0] t;
        t = m_prev[5:4];
`ifdef PRESENT_TYPE_BALANCE_EN
        if (t == exp_last) t = t + 2'd1;
        exp_last = t;
`endif
        exp_type = t;
        chk({tag, " drop"}, 16'(dropPresent), 16'd1);
        chk({tag, " type"}, 16'(nxt_present), {14'd0, t});
    endtask

    // From COOLDOWN with cooldown=3: three secClks, one zero-cooldown cycle, one IDLE
    // cycle, then the drop. secClk is also raised in the drop cycle and must be ignored.
    task automatic round(input string tag, input logic [1:0] pend_after);
        for (int i = 0; i < 3; i++) begin
            sec_pulse();
            chk({tag, " nodrop sec"}, 16'(dropPresent), 16'd0);
        end
        tick();
        chk({tag, " nodrop idle"}, 16'(dropPresent), 16'd0);
        tick();
        check_drop(tag);
        secClk = 1'b1;
        tick();
        secClk = 1'b0;
        chk({tag, " pend after"}, 16'(pending), 16'(pend_after));
        chk({tag, " pulse end"}, 16'(dropPresent), 16'd0);
    endtask

    initial begin
        resetN          = 1'b1;
        secClk          = 1'b0;
        ballPop         = 1'b0;
        presentsVisible = 1'b1;
        exp_type        = 2'd0;
`ifdef PRESENT_TYPE_BALANCE_EN
        exp_last        = 2'd0;
        prev_type       = 2'd0;
`endif
        repeat (3) tick();
        chk("rst drop", 16'(dropPresent), 16'd0);
        chk("rst pend", 16'(pending), 16'd0);
        chk("rst type", 16'(nxt_present), 16'd0);
        resetN = 1'b0;
        tick();
        chk("idle drop", 16'(dropPresent), 16'd0);

        // Latency: pop in N -> pending 1 at N+1 -> drop at N+2 -> pending 0 at N+3.
        ballPop = 1'b1;
        tick();
        ballPop = 1'b0;
        chk("lat pend1", 16'(pending), 16'd1);
        chk("lat nodrop", 16'(dropPresent), 16'd0);
        tick();
        check_drop("lat");
        tick();
        chk("lat pend0", 16'(pending), 16'd0);
        chk("lat single", 16'(dropPresent), 16'd0);
        for (int i = 0; i < 3; i++) sec_pulse();
        tick();
        tick();
        chk("lat quiet", 16'(dropPresent), 16'd0);

        // Cooldown spacing: pops in three consecutive cycles.
        ballPop = 1'b1;
        tick();
        chk("cd pend1", 16'(pending), 16'd1);
        tick();
        chk("cd pend2", 16'(pending), 16'd2);
        check_drop("cd1");
        secClk = 1'b1;
        tick();
        ballPop = 1'b0;
        secClk  = 1'b0;
        chk("cd pend after1", 16'(pending), 16'd2);
        chk("cd pulse end", 16'(dropPresent), 16'd0);
        round("cd2", 2'd1);
        round("cd3", 2'd0);

        // Reset held two cycles in the middle of COOLDOWN with a queued drop.
        ballPop = 1'b1;
        tick();
        ballPop = 1'b0;
        chk("rst2 pre pend", 16'(pending), 16'd1);
        resetN = 1'b1;
        tick();
        chk("rst2a pend", 16'(pending), 16'd0);
        tick();
        chk("rst2b drop", 16'(dropPresent), 16'd0);
        chk("rst2b pend", 16'(pending), 16'd0);
        chk("rst2b type", 16'(nxt_present), 16'd0);
        resetN = 1'b0;
`ifdef PRESENT_TYPE_BALANCE_EN
        exp_last = 2'd0;
`endif
        tick();
        chk("rst2 post drop", 16'(dropPresent), 16'd0);
        chk("rst2 post pend", 16'(pending), 16'd0);

        // Saturation: one drop, then five pops during COOLDOWN -> exactly three drops.
        ballPop = 1'b1;
        tick();
        ballPop = 1'b0;
        tick();
        check_drop("sat0");
        tick();
        chk("sat0 pend", 16'(pending), 16'd0);
        for (int i = 0; i < 5; i++) begin
            ballPop = 1'b1;
            tick();
            chk("sat pend", 16'(pending), (i < 3) ? 16'(i + 1) : 16'd3);
        end
        ballPop = 1'b0;
        round("sat1", 2'd2);
        round("sat2", 2'd1);
        round("sat3", 2'd0);
        for (int i = 0; i < 3; i++) sec_pulse();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("sat no4th", 16'(dropPresent), 16'd0);
        end

        // Visibility loss flushes the queue; nothing drops after it returns.
        ballPop = 1'b1;
        tick();
        ballPop = 1'b0;
        tick();
        check_drop("vis");
        tick();
        ballPop = 1'b1;
        tick();
        tick();
        ballPop = 1'b0;
        chk("vis pend2", 16'(pending), 16'd2);
        presentsVisible = 1'b0;
        tick();
        chk("vis flush", 16'(pending), 16'd0);
        chk("vis hold type", 16'(nxt_present), {14'd0, exp_type});
        ballPop = 1'b1;
        tick();
        ballPop = 1'b0;
        chk("vis pop ignored", 16'(pending), 16'd0);
        presentsVisible = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sec_pulse();
            chk("vis no drop", 16'(dropPresent), 16'd0);
        end
        chk("vis pend end", 16'(pending), 16'd0);

        // Visibility lost during DROP: the pulse completes, then straight to IDLE.
        ballPop = 1'b1;
        tick();
        ballPop = 1'b0;
        tick();
        check_drop("visd");
        presentsVisible = 1'b0;
        tick();
        chk("visd pend", 16'(pending), 16'd0);
        chk("visd one pulse", 16'(dropPresent), 16'd0);
        presentsVisible = 1'b1;
        tick();
        ballPop = 1'b1;
        tick();
        ballPop = 1'b0;
        tick();
        check_drop("visd idle");
        tick();
        for (int i = 0; i < 3; i++) sec_pulse();
        tick();
        tick();

        // DROP_PROB = 0 never accepts.
        for (int i = 0; i < 100; i++) begin
            ballPop = 1'b1;
            tick();
            chk("p0 pend", 16'(pend0), 16'd0);
            chk("p0 drop", 16'(drop0), 16'd0);
        end
        ballPop = 1'b0;
        resetN  = 1'b1;
        tick();
        tick();
        resetN  = 1'b0;
`ifdef PRESENT_TYPE_BALANCE_EN
        exp_last = 2'd0;
`endif
        tick();

        // Fifty isolated drops checking the type sequence.
        for (int i = 0; i < 50; i++) begin
            ballPop = 1'b1;
            tick();
            ballPop = 1'b0;
            tick();
            check_drop("seq");
`ifdef PRESENT_TYPE_BALANCE_EN
            if (i > 0) begin
                chk("bal no repeat", 16'(nxt_present[1:0] != prev_type), 16'd1);
            end
            prev_type = nxt_present[1:0];
`endif
            tick();
            for (int k = 0; k < 3; k++) sec_pulse();
            tick();
            tick();
            chk("seq idle pend", 16'(pending), 16'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
